// File: rtl/decode_seq_ctrl.sv
// decode_seq_ctrl: front-end sequencer that owns the PC, fetches over imem req/ack,
// strobes the decoder for one cycle, then issues to execute or raises a trap.
module decode_seq_ctrl #(
   parameter logic [31:0] RESET_PC      = 32'h0200_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_dec_en,
   output logic [31:0] o_dec_instr,
   input  logic [1:0]  i_dec_invalid,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_pc,
   output logic [31:0] o_out_instr,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_trap_valid,
   output logic [2:0]  o_trap_cause,
   output logic [31:0] o_trap_pc,
   output logic [31:0] o_issue_count
);

   localparam int unsigned XLEN        = 32;
   localparam int unsigned CW          = 8;
   localparam logic [CW:0] TIMEOUT_LIM = (CW+1)'(FETCH_TIMEOUT);
   localparam logic [2:0]  CAUSE_TMO   = 3'b100;
   localparam logic [2:0]  CAUSE_ALIGN = 3'b101;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_ISSUE  = 3'd2,
      S_FLUSH  = 3'd3,
      S_TRAP   = 3'd4
   } state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_pc;
   logic [CW-1:0]     r_cnt;
   logic              r_imem_req;
   logic [XLEN-1:0]   r_imem_addr;
   logic              r_dec_en;
   logic [XLEN-1:0]   r_dec_instr;
   logic              r_out_valid;
   logic [XLEN-1:0]   r_out_pc;
   logic [XLEN-1:0]   r_out_instr;
   logic              r_trap_valid;
   logic [2:0]        r_trap_cause;
   logic [XLEN-1:0]   r_trap_pc;
   logic [XLEN-1:0]   r_issue_count;

   state_t            w_state_nxt;
   logic [XLEN-1:0]   w_pc_nxt;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_imem_req_nxt;
   logic [XLEN-1:0]   w_imem_addr_nxt;
   logic              w_dec_en_nxt;
   logic [XLEN-1:0]   w_dec_instr_nxt;
   logic              w_out_valid_nxt;
   logic [XLEN-1:0]   w_out_pc_nxt;
   logic [XLEN-1:0]   w_out_instr_nxt;
   logic              w_trap_valid_nxt;
   logic [2:0]        w_trap_cause_nxt;
   logic [XLEN-1:0]   w_trap_pc_nxt;
   logic [XLEN-1:0]   w_issue_count_nxt;

   logic              w_redir_bad;
   logic              w_redir_ok;
   logic              w_ack;
   logic              w_pend;
   logic              w_timeout;
   logic              w_accept;
   logic              w_decode_ok;

   assign w_redir_bad = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);
   assign w_redir_ok  = i_redirect_valid & ~w_redir_bad;
   assign w_ack       = r_imem_req & i_imem_ack;
   assign w_pend      = r_imem_req & ~i_imem_ack;
   assign w_timeout   = w_pend & (({1'b0, r_cnt} + (CW+1)'(1)) >= TIMEOUT_LIM);
   assign w_accept    = (r_state == S_ISSUE) & i_out_ready;
   assign w_decode_ok = (i_dec_invalid == 2'b00);

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_cnt         <= '0;
         r_imem_req    <= 1'b0;
         r_imem_addr   <= RESET_PC;
         r_dec_en      <= 1'b0;
         r_dec_instr   <= '0;
         r_out_valid   <= 1'b0;
         r_out_pc      <= '0;
         r_out_instr   <= '0;
         r_trap_valid  <= 1'b0;
         r_trap_cause  <= '0;
         r_trap_pc     <= '0;
         r_issue_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_cnt         <= w_cnt_nxt;
         r_imem_req    <= w_imem_req_nxt;
         r_imem_addr   <= w_imem_addr_nxt;
         r_dec_en      <= w_dec_en_nxt;
         r_dec_instr   <= w_dec_instr_nxt;
         r_out_valid   <= w_out_valid_nxt;
         r_out_pc      <= w_out_pc_nxt;
         r_out_instr   <= w_out_instr_nxt;
         r_trap_valid  <= w_trap_valid_nxt;
         r_trap_cause  <= w_trap_cause_nxt;
         r_trap_pc     <= w_trap_pc_nxt;
         r_issue_count <= w_issue_count_nxt;
      end
   end

   // Next state; redirects win over everything, an outstanding fetch must drain in FLUSH
   always_comb begin
      w_state_nxt = r_state;
      if (w_redir_bad) begin
         w_state_nxt = S_TRAP;
      end else if (w_redir_ok) begin
         w_state_nxt = w_pend ? S_FLUSH : S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_ack)          w_state_nxt = S_DECODE;
               else if (w_timeout) w_state_nxt = S_TRAP;
            end
            S_DECODE: w_state_nxt = w_decode_ok ? S_ISSUE : S_TRAP;
            S_ISSUE:  if (w_accept) w_state_nxt = S_FETCH;
            S_FLUSH:  if (w_ack || w_timeout) w_state_nxt = S_FETCH;
            S_TRAP:   w_state_nxt = S_TRAP;
            default:  w_state_nxt = S_FETCH;
         endcase
      end
   end

   // Next values for the registered outputs and datapath
   always_comb begin
      w_pc_nxt          = r_pc;
      w_cnt_nxt         = '0;
      w_dec_instr_nxt   = r_dec_instr;
      w_out_pc_nxt      = r_out_pc;
      w_out_instr_nxt   = r_out_instr;
      w_trap_cause_nxt  = r_trap_cause;
      w_trap_pc_nxt     = r_trap_pc;
      w_issue_count_nxt = r_issue_count;

      if (w_redir_bad) begin
         w_trap_cause_nxt = CAUSE_ALIGN;
         w_trap_pc_nxt    = i_redirect_pc;
      end else if (w_redir_ok) begin
         w_pc_nxt = i_redirect_pc;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_ack) begin
                  w_dec_instr_nxt = i_imem_rdata;
               end else if (w_timeout) begin
                  w_trap_cause_nxt = CAUSE_TMO;
                  w_trap_pc_nxt    = r_pc;
               end
            end
            S_DECODE: begin
               if (w_decode_ok) begin
                  w_out_instr_nxt = r_dec_instr;
                  w_out_pc_nxt    = r_pc;
               end else begin
                  w_trap_cause_nxt = {1'b0, i_dec_invalid};
                  w_trap_pc_nxt    = r_pc;
               end
            end
            S_ISSUE: begin
               if (w_accept) begin
                  w_pc_nxt          = r_pc + XLEN'(4);
                  w_issue_count_nxt = r_issue_count + XLEN'(1);
               end
            end
            default: ;
         endcase
      end

      // Timeout counter spans the whole life of one outstanding request, FLUSH included
      if (w_pend && ((w_state_nxt == S_FLUSH) ||
                     ((w_state_nxt == S_FETCH) && (r_state == S_FETCH))))
         w_cnt_nxt = r_cnt + CW'(1);

      w_imem_req_nxt   = (w_state_nxt == S_FETCH) || (w_state_nxt == S_FLUSH);
      w_imem_addr_nxt  = (w_state_nxt == S_FLUSH) ? r_imem_addr : w_pc_nxt;
      w_dec_en_nxt     = (w_state_nxt == S_DECODE);
      w_out_valid_nxt  = (w_state_nxt == S_ISSUE);
      w_trap_valid_nxt = (w_state_nxt == S_TRAP);
   end

   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_imem_addr;
   assign o_dec_en      = r_dec_en;
   assign o_dec_instr   = r_dec_instr;
   assign o_out_valid   = r_out_valid;
   assign o_out_pc      = r_out_pc;
   assign o_out_instr   = r_out_instr;
   assign o_trap_valid  = r_trap_valid;
   assign o_trap_cause  = r_trap_cause;
   assign o_trap_pc     = r_trap_pc;
   assign o_issue_count = r_issue_count;

endmodule

// File: tb/tb_decode_seq_ctrl.sv
// Bench for decode_seq_ctrl: directed scenarios, then a randomized run scored against a
// program-flow model (expected PC stream, memory contents as a hash of the address).
module tb_decode_seq_ctrl;

   localparam logic [31:0] RPC = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dec_en;
   logic [31:0] dec_instr;
   logic [1:0]  dec_invalid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        redir;
   logic [31:0] redir_pc;
   logic        trap_valid;
   logic [2:0]  trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] issue_count;

   int total = 0;
   int bad   = 0;

   decode_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
      .o_dec_en(dec_en), .o_dec_instr(dec_instr), .i_dec_invalid(dec_invalid),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_pc(out_pc), .o_out_instr(out_instr),
      .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
      .o_trap_valid(trap_valid), .o_trap_cause(trap_cause), .o_trap_pc(trap_pc),
      .o_issue_count(issue_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      imem_ack = 1'b0; imem_rdata = '0; dec_invalid = 2'b00;
      out_ready = 1'b0; redir = 1'b0; redir_pc = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   // Brings a fresh block to ISSUE holding word w at RESET_PC
   task automatic goto_issue(input logic [31:0] w);
      do_reset();
      cyc();
      imem_ack = 1'b1; imem_rdata = w;
      cyc();
      imem_ack = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
      total++; if (imem_addr !== RPC)    begin bad++; $display("FAIL rst_addr got=%h want=%h", imem_addr, RPC); end
      total++; if (dec_en !== 1'b0)      begin bad++; $display("FAIL rst_dec_en got=%b want=0", dec_en); end
      total++; if (dec_instr !== 32'h0)  begin bad++; $display("FAIL rst_dec_instr got=%h want=0", dec_instr); end
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (out_pc !== 32'h0)     begin bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc); end
      total++; if (out_instr !== 32'h0)  begin bad++; $display("FAIL rst_out_instr got=%h want=0", out_instr); end
      total++; if (trap_valid !== 1'b0)  begin bad++; $display("FAIL rst_trap_valid got=%b want=0", trap_valid); end
      total++; if (trap_cause !== 3'b0)  begin bad++; $display("FAIL rst_trap_cause got=%b want=0", trap_cause); end
      total++; if (trap_pc !== 32'h0)    begin bad++; $display("FAIL rst_trap_pc got=%h want=0", trap_pc); end
      total++; if (issue_count !== 32'h0) begin bad++; $display("FAIL rst_count got=%0d want=0", issue_count); end
      rst = 1'b0;
      cyc();
      total++; if (imem_req !== 1'b1)    begin bad++; $display("FAIL post_rst_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== RPC)    begin bad++; $display("FAIL post_rst_addr got=%h want=%h", imem_addr, RPC); end
   endtask

   task automatic test_basic_fetch();
      do_reset();
      cyc();
      cyc();
      cyc();
      imem_ack = 1'b1; imem_rdata = 32'h0000_0797; out_ready = 1'b1;
      cyc();
      imem_ack = 1'b0;
      total++; if (dec_en !== 1'b1)      begin bad++; $display("FAIL bf_dec_en got=%b want=1", dec_en); end
      total++; if (dec_instr !== 32'h0000_0797) begin bad++; $display("FAIL bf_dec_instr got=%h want=00000797", dec_instr); end
      total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL bf_req_in_decode got=%b want=0", imem_req); end
      cyc();
      total++; if (dec_en !== 1'b0)      begin bad++; $display("FAIL bf_dec_en_once got=%b want=0", dec_en); end
      total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL bf_out_valid got=%b want=1", out_valid); end
      total++; if (out_pc !== RPC)       begin bad++; $display("FAIL bf_out_pc got=%h want=%h", out_pc, RPC); end
      total++; if (out_instr !== 32'h0000_0797) begin bad++; $display("FAIL bf_out_instr got=%h want=00000797", out_instr); end
      cyc();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL bf_out_drop got=%b want=0", out_valid); end
      total++; if (imem_req !== 1'b1)    begin bad++; $display("FAIL bf_next_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== RPC + 32'd4) begin bad++; $display("FAIL bf_next_addr got=%h want=%h", imem_addr, RPC + 32'd4); end
      total++; if (issue_count !== 32'd1) begin bad++; $display("FAIL bf_count got=%0d want=1", issue_count); end
   endtask

   task automatic test_stall();
      logic [31:0] words [2];
      words[0] = 32'h02c7_8793;
      words[1] = 32'h3057_93f3;
      do_reset();
      cyc();
      for (int k = 0; k < 2; k++) begin
         imem_ack = 1'b1; imem_rdata = words[k];
         cyc();
         imem_ack = 1'b0;
         cyc();
         for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL st_hold_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (out_instr !== words[k]) begin bad++; $display("FAIL st_hold_instr[%0d] got=%h want=%h", i, out_instr, words[k]); end
            total++; if (out_pc !== RPC + 32'(4 * k)) begin bad++; $display("FAIL st_hold_pc[%0d] got=%h want=%h", i, out_pc, RPC + 32'(4 * k)); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_no_req[%0d] got=%b want=0", i, imem_req); end
            cyc();
         end
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
         total++; if (issue_count !== 32'(k + 1)) begin bad++; $display("FAIL st_count got=%0d want=%0d", issue_count, k + 1); end
         total++; if (imem_addr !== RPC + 32'(4 * (k + 1))) begin bad++; $display("FAIL st_addr got=%h want=%h", imem_addr, RPC + 32'(4 * (k + 1))); end
      end
   endtask

   task automatic test_decode_trap();
      do_reset();
      cyc();
      imem_ack = 1'b1; imem_rdata = 32'h0;
      cyc();
      imem_ack = 1'b0; dec_invalid = 2'b01;
      cyc();
      dec_invalid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         total++; if (trap_valid !== 1'b1) begin bad++; $display("FAIL dt_trap_valid[%0d] got=%b want=1", i, trap_valid); end
         total++; if (imem_req !== 1'b0)   begin bad++; $display("FAIL dt_no_req[%0d] got=%b want=0", i, imem_req); end
         cyc();
      end
      total++; if (trap_cause !== 3'b001) begin bad++; $display("FAIL dt_cause got=%b want=001", trap_cause); end
      total++; if (trap_pc !== RPC)       begin bad++; $display("FAIL dt_trap_pc got=%h want=%h", trap_pc, RPC); end
      total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL dt_no_issue got=%b want=0", out_valid); end
      redir = 1'b1; redir_pc = 32'h0200_0100;
      cyc();
      redir = 1'b0;
      total++; if (trap_valid !== 1'b0)   begin bad++; $display("FAIL dt_trap_clear got=%b want=0", trap_valid); end
      total++; if (imem_req !== 1'b1)     begin bad++; $display("FAIL dt_refetch_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== 32'h0200_0100) begin bad++; $display("FAIL dt_refetch_addr got=%h want=02000100", imem_addr); end
   endtask

   task automatic test_flush();
      do_reset();
      cyc();
      redir = 1'b1; redir_pc = 32'h0200_00cc;
      cyc();
      redir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fl_req_held[%0d] got=%b want=1", i, imem_req); end
         total++; if (imem_addr !== RPC) begin bad++; $display("FAIL fl_old_addr[%0d] got=%h want=%h", i, imem_addr, RPC); end
         cyc();
      end
      imem_ack = 1'b1; imem_rdata = 32'h1a50_00ef;
      cyc();
      imem_ack = 1'b0;
      total++; if (dec_en !== 1'b0)   begin bad++; $display("FAIL fl_discard_dec got=%b want=0", dec_en); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fl_new_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== 32'h0200_00cc) begin bad++; $display("FAIL fl_new_addr got=%h want=020000cc", imem_addr); end
      cyc();
      total++; if (dec_en !== 1'b0)   begin bad++; $display("FAIL fl_discard_dec2 got=%b want=0", dec_en); end
      imem_ack = 1'b1; imem_rdata = 32'h00c0_0093;
      cyc();
      imem_ack = 1'b0;
      cyc();
      total++; if (out_pc !== 32'h0200_00cc) begin bad++; $display("FAIL fl_issue_pc got=%h want=020000cc", out_pc); end
      total++; if (out_instr !== 32'h00c0_0093) begin bad++; $display("FAIL fl_issue_instr got=%h want=00c00093", out_instr); end
   endtask

   task automatic test_timeout();
      do_reset();
      cyc();
      for (int i = 0; i < 15; i++) begin
         cyc();
         total++; if (trap_valid !== 1'b0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL to_early[%0d] got trap=%b req=%b want trap=0 req=1", i, trap_valid, imem_req);
         end
      end
      cyc();
      total++; if (trap_valid !== 1'b1) begin bad++; $display("FAIL to_trap got=%b want=1", trap_valid); end
      total++; if (trap_cause !== 3'b100) begin bad++; $display("FAIL to_cause got=%b want=100", trap_cause); end
      total++; if (trap_pc !== RPC) begin bad++; $display("FAIL to_trap_pc got=%h want=%h", trap_pc, RPC); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b want=0", imem_req); end
      redir = 1'b1; redir_pc = 32'h0200_0002;
      cyc();
      redir = 1'b0;
      total++; if (trap_cause !== 3'b101) begin bad++; $display("FAIL to_align_cause got=%b want=101", trap_cause); end
      total++; if (trap_pc !== 32'h0200_0002) begin bad++; $display("FAIL to_align_pc got=%h want=02000002", trap_pc); end
   endtask

   task automatic test_misaligned();
      goto_issue(32'h0000_0013);
      out_ready = 1'b1; redir = 1'b1; redir_pc = 32'h0200_0002;
      cyc();
      out_ready = 1'b0; redir = 1'b0;
      total++; if (trap_valid !== 1'b1) begin bad++; $display("FAIL ma_trap got=%b want=1", trap_valid); end
      total++; if (trap_cause !== 3'b101) begin bad++; $display("FAIL ma_cause got=%b want=101", trap_cause); end
      total++; if (trap_pc !== 32'h0200_0002) begin bad++; $display("FAIL ma_trap_pc got=%h want=02000002", trap_pc); end
      total++; if (issue_count !== 32'd0) begin bad++; $display("FAIL ma_count got=%0d want=0", issue_count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ma_out_drop got=%b want=0", out_valid); end
      total++; if (imem_addr !== RPC) begin bad++; $display("FAIL ma_pc_kept got=%h want=%h", imem_addr, RPC); end
      goto_issue(32'h0000_0013);
      out_ready = 1'b1; redir = 1'b1; redir_pc = RPC + 32'h40;
      cyc();
      out_ready = 1'b0; redir = 1'b0;
      total++; if (issue_count !== 32'd0) begin bad++; $display("FAIL ma_redir_no_count got=%0d want=0", issue_count); end
      total++; if (imem_addr !== RPC + 32'h40) begin bad++; $display("FAIL ma_redir_addr got=%h want=%h", imem_addr, RPC + 32'h40); end
   endtask

   task automatic test_reset_mid();
      goto_issue(32'h0000_0297);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'h0000_0317;
      cyc();
      imem_ack = 1'b0;
      cyc();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_in_issue got=%b want=1", out_valid); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b want=0", out_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b want=0", imem_req); end
      total++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || dec_instr !== 32'h0) begin
         bad++; $display("FAIL rm_regs got pc=%h instr=%h dec=%h want 0", out_pc, out_instr, dec_instr);
      end
      total++; if (issue_count !== 32'h0) begin bad++; $display("FAIL rm_count got=%0d want=0", issue_count); end
      cyc();
      total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
         bad++; $display("FAIL rm_refetch got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC);
      end
   endtask

   // Random memory latency, ready and redirects; every issue must follow the program order
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
      logic [31:0] last_ack_addr;
      logic [31:0] prev_addr;
      logic        prev_hold;
      int unsigned lat;
      do_reset();
      exp_pc = RPC; exp_cnt = '0; last_ack_addr = '0;
      prev_hold = 1'b0; prev_addr = '0; lat = 0;
      for (int n = 0; n < 3000; n++) begin
         if (prev_hold) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               bad++; $display("FAIL rnd_req_hold cyc=%0d got req=%b addr=%h want req=1 addr=%h", n, imem_req, imem_addr, prev_addr);
            end
         end
         if (dec_en === 1'b1) begin
            total++; if (dec_instr !== memfn(last_ack_addr)) begin
               bad++; $display("FAIL rnd_dec_instr cyc=%0d got=%h want=%h", n, dec_instr, memfn(last_ack_addr));
            end
         end
         total++; if (issue_count !== exp_cnt || trap_valid !== 1'b0) begin
            bad++; $display("FAIL rnd_count cyc=%0d got cnt=%0d trap=%b want cnt=%0d trap=0", n, issue_count, trap_valid, exp_cnt);
         end

         if (imem_req && (lat >= 4 || $urandom_range(0, 2) == 0)) begin
            imem_ack = 1'b1; imem_rdata = memfn(imem_addr); last_ack_addr = imem_addr; lat = 0;
         end else begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            lat = imem_req ? lat + 1 : 0;
         end
         out_ready = 1'($urandom_range(0, 1));
         redir     = ($urandom_range(0, 19) == 0);
         redir_pc  = RPC + 32'($urandom_range(0, 63)) * 32'd4;

         if (redir) begin
            exp_pc = redir_pc;
         end else if (out_valid && out_ready) begin
            total++; if (out_pc !== exp_pc || out_instr !== memfn(exp_pc)) begin
               bad++; $display("FAIL rnd_issue cyc=%0d got pc=%h instr=%h want pc=%h instr=%h", n, out_pc, out_instr, exp_pc, memfn(exp_pc));
            end
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
         end
         prev_hold = imem_req && !imem_ack;
         prev_addr = imem_addr;
         cyc();
      end
      idle_inputs();
      total++; if (exp_cnt < 32'd100) begin bad++; $display("FAIL rnd_progress got=%0d issues want>=100", exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_decode_trap();
      test_flush();
      test_timeout();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
